signedmul_seq: RTL and testbench
================================

Name: signedmul_seq

Overview:
- Parametrised sequential sign-magnitude fixed-point multiplier for the LSTM datapath.
- Converts two's-complement operands to magnitudes and multiplies them with an iterative shift-add engine, one multiplier bit per cycle.
- Rescales the product by FRAC bits, with optional rounding and saturation.
- Uses valid/ready handshakes on both sides, so it can sit between gate-accumulation stages with backpressure.

Parameters:
- WIDTH, 16: operand and result width, two's complement.
- FRAC, 12: fractional bits of operands and result. The product is shifted right by FRAC. Legal range 1..WIDTH-1.
- MAG_BITS, 15: low magnitude bits used in the multiply. Legal range 2..WIDTH-1. Also sets the iteration count.
- ROUND, 1: 1 = round half away from zero (add 2^(FRAC-1) to the magnitude before the shift); 0 = truncate the magnitude.
- SAT, 1: 1 = saturate on overflow; 0 = wrap.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands a, b are valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  multiplicand, two's complement Q(WIDTH-FRAC).FRAC
- b  in  WIDTH  multiplier, same format as a
- out_valid  out  1  c and ovf are valid
- out_ready  in  1  downstream accepts the result
- c  out  WIDTH  product, same format as a
- ovf  out  1  magnitude overflowed the output range (sticky per result)

Behaviour:
- Reset: rst is synchronous and active-high.
  - State goes to IDLE; out_valid=0, c=0, ovf=0.
  - in_ready=0 while rst=1, then 1 from the first cycle after rst drops.
  - Reset mid-operation aborts the operation; no result is emitted.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready (edge t0), register:
    - sign = a[W-1]^b[W-1]
    - |a|, |b|, each taken modulo 2^MAG_BITS
    - accumulator cleared, count=0
  - Go to BUSY.
- Magnitude of -2^(W-1) clamps to 2^(W-1)-1 before MAG_BITS truncation.
- State BUSY:
  - in_ready=0.
  - Each cycle: if the multiplier LSB is 1, acc += |a| << count; then shift the multiplier right and increment count.
  - acc is 2*MAG_BITS bits and cannot overflow.
  - After MAG_BITS iterations (edges t0+1 .. t0+MAG_BITS), go to FINAL.
- State FINAL (one cycle, edge t0+MAG_BITS+1):
  - m = (acc + (ROUND ? 2^(FRAC-1) : 0)) >> FRAC.
  - If m==0: c=0 (no negative zero), ovf=0.
  - Positive limit: m > 2^(W-1)-1.
    - SAT=1: c = 2^(W-1)-1, ovf=1.
    - SAT=0: c = m[W-1:0], ovf=1.
  - Negative limit: m > 2^(W-1).
    - SAT=1: c = -2^(W-1), ovf=1.
    - SAT=0: c = -(m[W-1:0]) mod 2^W, ovf=1.
    - m == 2^(W-1) is exact: c = -2^(W-1), ovf=0.
  - Otherwise c = sign ? -m : m, ovf=0.
  - out_valid goes to 1; go to DONE.
- Latency: out_valid first high in the cycle after edge t0+MAG_BITS+1, i.e. MAG_BITS+1 cycles after the accept edge.
- State DONE:
  - c and ovf are held stable while out_valid=1 and out_ready=0. in_ready=0.
  - On out_valid&&out_ready: out_valid=0, go to IDLE.
  - c keeps its last value; its value is don't-care while out_valid=0.
- Throughput: at best one result per MAG_BITS+3 cycles. Operand acceptance and result handoff never share a cycle.
- in_valid while in_ready=0 is ignored. a and b are sampled only on the accept edge.

Test Plan:
- Reset, then a=0x1000, b=0x2000, out_ready=1:
  - c=0x2000, ovf=0.
  - out_valid rises exactly 16 cycles after the accept edge.
  - in_ready=0 throughout the operation.
- a=0xF000, b=0x1800 → c=0xE800, ovf=0.
- Rounding, a=0x0001, b=0x0800:
  - ROUND=1 → c=0x0001.
  - ROUND=0 build → c=0x0000.
- Rounding, negative: a=0xFFFF, b=0x0800, ROUND=1 → c=0xFFFF.
- Saturation:
  - a=0x7FFF, b=0x7FFF → c=0x7FFF, ovf=1.
  - a=0x8000, b=0x7FFF → c=0x8000, ovf=1.
  - SAT=0 build, a=0x7FFF, b=0x7FFF → c=0xFFF0, ovf=1.
- Signed zero: a=0x0000, b=0x8000 → c=0x0000 (not negative zero).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - c and ovf are stable; in_ready=0; a new in_valid is ignored.
  - Release out_ready → one handshake; in_ready=1 next cycle.
- Reset mid-BUSY: assert rst at iteration 7.
  - out_valid stays 0, c=0.
  - The next operation (a=0x1000, b=0x1000) yields c=0x1000 with normal latency.

Source files
------------

// File: rtl/signedmul_seq_if.sv
// Operand/result handshake bundle for the sequential sign-magnitude multiplier.
// The master side supplies operands and accepts results; the slave side is the multiplier.
interface signedmul_seq_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, c, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, c, ovf
  );
endinterface

// File: rtl/signedmul_seq.sv
// Sequential sign-magnitude fixed-point multiplier: one multiplier bit per cycle,
// then rescale by FRAC with optional round-half-away-from-zero and saturation.
module signedmul_seq #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 12,
  parameter int MAG_BITS = 15,
  parameter int ROUND    = 1,
  parameter int SAT      = 1
) (
  input  logic            clk,
  input  logic            rst,
  signedmul_seq_if.slave  bus
);

  localparam int PW = 2 * MAG_BITS;
  localparam int EW = (PW + 1 > WIDTH + 1) ? PW + 1 : WIDTH + 1;
  localparam int CW = $clog2(MAG_BITS + 1);

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_VAL  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [EW-1:0]    NEG_LIM  = EW'(1'b1) << (WIDTH - 1);
  localparam logic [EW-1:0]    POS_LIM  = NEG_LIM - EW'(1'b1);
  localparam logic [EW-1:0]    RND_ADD  = (ROUND != 0) ? (EW'(1'b1) << (FRAC - 1)) : {EW{1'b0}};
  localparam logic [CW-1:0]    LAST_CNT = CW'(MAG_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The most negative value has no positive twin, so it clamps to the largest positive one.
  function automatic logic [MAG_BITS-1:0] mag_of(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] m;
    if (v[WIDTH-1] == 1'b0) begin
      m = v;
    end else if (v == MIN_VAL) begin
      m = MAX_VAL;
    end else begin
      m = -v;
    end
    return m[MAG_BITS-1:0];
  endfunction

  state_t              state_r, state_n;
  logic                in_ready_r;
  logic                out_valid_r;
  logic [WIDTH-1:0]    c_r;
  logic                ovf_r;
  logic                sign_r;
  logic [PW-1:0]       mcand_r;
  logic [MAG_BITS-1:0] mplier_r;
  logic [PW-1:0]       acc_r;
  logic [CW-1:0]       cnt_r;

  logic                accept_s;
  logic                handoff_s;
  logic [EW-1:0]       sum_s;
  logic [EW-1:0]       m_s;
  logic [WIDTH-1:0]    m_low_s;
  logic [WIDTH-1:0]    c_n_s;
  logic                ovf_n_s;

  assign accept_s  = bus.in_valid && in_ready_r;
  assign handoff_s = out_valid_r && bus.out_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state decode.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_n = BUSY;
        end else begin
          state_n = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == LAST_CNT) begin
          state_n = FINAL;
        end else begin
          state_n = BUSY;
        end
      end
      FINAL: begin
        state_n = DONE;
      end
      DONE: begin
        if (handoff_s) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Rescale the magnitude and apply sign, overflow and saturation rules.
  always_comb begin
    sum_s   = EW'(acc_r) + RND_ADD;
    m_s     = sum_s >> FRAC;
    m_low_s = m_s[WIDTH-1:0];
    c_n_s   = {WIDTH{1'b0}};
    ovf_n_s = 1'b0;
    if (m_s == {EW{1'b0}}) begin
      c_n_s   = {WIDTH{1'b0}};
      ovf_n_s = 1'b0;
    end else if (!sign_r) begin
      if (m_s > POS_LIM) begin
        c_n_s   = (SAT != 0) ? MAX_VAL : m_low_s;
        ovf_n_s = 1'b1;
      end else begin
        c_n_s   = m_low_s;
        ovf_n_s = 1'b0;
      end
    end else begin
      // m equal to the negative limit is still representable exactly.
      if (m_s > NEG_LIM) begin
        c_n_s   = (SAT != 0) ? MIN_VAL : -m_low_s;
        ovf_n_s = 1'b1;
      end else begin
        c_n_s   = -m_low_s;
        ovf_n_s = 1'b0;
      end
    end
  end

  // Operand capture, shift-add iterations, result register and handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      c_r         <= {WIDTH{1'b0}};
      ovf_r       <= 1'b0;
      sign_r      <= 1'b0;
      mcand_r     <= {PW{1'b0}};
      mplier_r    <= {MAG_BITS{1'b0}};
      acc_r       <= {PW{1'b0}};
      cnt_r       <= {CW{1'b0}};
    end else begin
      in_ready_r <= (state_n == IDLE);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            sign_r   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            mcand_r  <= {{MAG_BITS{1'b0}}, mag_of(bus.a)};
            mplier_r <= mag_of(bus.b);
            acc_r    <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
          end
        end
        BUSY: begin
          // The multiplicand is pre-shifted each step, so it always equals |a| << count.
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CW'(1'b1);
        end
        FINAL: begin
          c_r         <= c_n_s;
          ovf_r       <= ovf_n_s;
          out_valid_r <= 1'b1;
        end
        DONE: begin
          if (handoff_s) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.c         = c_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_signedmul_seq.sv
// Bench for signedmul_seq: default, truncating (ROUND=0) and wrapping (SAT=0) builds
// driven in lockstep, with expected results queued per build and popped on each handoff.
module tb_signedmul_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  signedmul_seq_if #(.WIDTH(16)) bus0 ();
  signedmul_seq_if #(.WIDTH(16)) bus1 ();
  signedmul_seq_if #(.WIDTH(16)) bus2 ();

  signedmul_seq #(.WIDTH(16), .FRAC(12), .MAG_BITS(15), .ROUND(1), .SAT(1))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  signedmul_seq #(.WIDTH(16), .FRAC(12), .MAG_BITS(15), .ROUND(0), .SAT(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  signedmul_seq #(.WIDTH(16), .FRAC(12), .MAG_BITS(15), .ROUND(1), .SAT(0))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic        ovf;
    logic [15:0] c_r0;
    logic        ovf_r0;
    logic [15:0] c_s0;
    logic        ovf_s0;
  } vec_t;

  typedef struct packed {
    logic [15:0] c;
    logic        ovf;
  } exp_t;

  vec_t tbl [16];
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic mon_one(input int k, input logic [15:0] c, input logic ovf);
    exp_t e;
    int   sz;
    sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_out dut%0d: got c=%h, expected no result", k, c);
    end else begin
      if (k == 0) e = q0.pop_front();
      else if (k == 1) e = q1.pop_front();
      else e = q2.pop_front();
      chk($sformatf("c_dut%0d", k), c, e.c);
      chk($sformatf("ovf_dut%0d", k), {15'd0, ovf}, {15'd0, e.ovf});
    end
  endtask

  task automatic set_in(input logic v, input logic [15:0] a, input logic [15:0] b);
    bus0.in_valid = v; bus0.a = a; bus0.b = b;
    bus1.in_valid = v; bus1.a = a; bus1.b = b;
    bus2.in_valid = v; bus2.a = a; bus2.b = b;
  endtask

  task automatic set_oready(input logic r);
    bus0.out_ready = r;
    bus1.out_ready = r;
    bus2.out_ready = r;
  endtask

  task automatic push_exp(input int idx);
    q0.push_back('{c: tbl[idx].c,    ovf: tbl[idx].ovf});
    q1.push_back('{c: tbl[idx].c_r0, ovf: tbl[idx].ovf_r0});
    q2.push_back('{c: tbl[idx].c_s0, ovf: tbl[idx].ovf_s0});
  endtask

  // Drive vector idx until accepted; returns once the accept edge has passed.
  task automatic launch(input int idx, output bit ok);
    int t;
    @(posedge clk); #1;
    set_in(1'b1, tbl[idx].a, tbl[idx].b);
    push_exp(idx);
    ok = 1'b0;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus0.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    set_in(1'b0, 16'h0000, 16'h0000);
    if (!ok) chk("accept_timeout", 16'd0, 16'd1);
  endtask

  // Count cycles from the accept edge until out_valid; in_ready must stay low meanwhile.
  task automatic wait_valid(output int lat);
    bit busy_ok;
    busy_ok = 1'b1;
    lat = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus0.out_valid) break;
      if (bus0.in_ready) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
    end
    chk("in_ready_busy", {15'd0, busy_ok}, 16'd1);
  endtask

  task automatic do_op(input int idx, input bit chk_lat);
    bit ok;
    int lat;
    launch(idx, ok);
    if (ok) begin
      wait_valid(lat);
      if (chk_lat) chk("latency", 16'(lat), 16'd16);
      @(posedge clk); #1;
      @(negedge clk);
      chk("out_valid_after_hs", {15'd0, bus0.out_valid}, 16'd0);
      chk("in_ready_after_hs", {15'd0, bus0.in_ready}, 16'd1);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int lat;
    bit seen;
    tbl[0]  = '{16'h1000, 16'h2000, 16'h2000, 1'b0, 16'h2000, 1'b0, 16'h2000, 1'b0};
    tbl[1]  = '{16'hF000, 16'h1800, 16'hE800, 1'b0, 16'hE800, 1'b0, 16'hE800, 1'b0};
    tbl[2]  = '{16'h0001, 16'h0800, 16'h0001, 1'b0, 16'h0000, 1'b0, 16'h0001, 1'b0};
    tbl[3]  = '{16'hFFFF, 16'h0800, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 16'hFFFF, 1'b0};
    tbl[4]  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 16'hFFF0, 1'b1};
    tbl[5]  = '{16'h8000, 16'h7FFF, 16'h8000, 1'b1, 16'h8000, 1'b1, 16'h0010, 1'b1};
    tbl[6]  = '{16'h0000, 16'h8000, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[7]  = '{16'h1000, 16'h1000, 16'h1000, 1'b0, 16'h1000, 1'b0, 16'h1000, 1'b0};
    tbl[8]  = '{16'h8000, 16'h8000, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 16'hFFF0, 1'b1};
    tbl[9]  = '{16'hE000, 16'h1800, 16'hD000, 1'b0, 16'hD000, 1'b0, 16'hD000, 1'b0};
    tbl[10] = '{16'h4000, 16'hE000, 16'h8000, 1'b0, 16'h8000, 1'b0, 16'h8000, 1'b0};
    tbl[11] = '{16'h4000, 16'h2000, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 16'h8000, 1'b1};
    tbl[12] = '{16'h0003, 16'h0800, 16'h0002, 1'b0, 16'h0001, 1'b0, 16'h0002, 1'b0};
    tbl[13] = '{16'hFFFD, 16'h0800, 16'hFFFE, 1'b0, 16'hFFFF, 1'b0, 16'hFFFE, 1'b0};
    tbl[14] = '{16'h1234, 16'h0100, 16'h0123, 1'b0, 16'h0123, 1'b0, 16'h0123, 1'b0};
    tbl[15] = '{16'hC000, 16'hC000, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 16'h0000, 1'b1};

    set_in(1'b0, 16'h0000, 16'h0000);
    set_oready(1'b1);

    fork
      forever begin
        @(negedge clk);
        if (bus0.out_valid && bus0.out_ready) mon_one(0, bus0.c, bus0.ovf);
        if (bus1.out_valid && bus1.out_ready) mon_one(1, bus1.c, bus1.ovf);
        if (bus2.out_valid && bus2.out_ready) mon_one(2, bus2.c, bus2.ovf);
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {15'd0, bus0.out_valid}, 16'd0);
    chk("rst_c", bus0.c, 16'h0000);
    chk("rst_ovf", {15'd0, bus0.ovf}, 16'd0);
    chk("rst_in_ready", {15'd0, bus0.in_ready}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_before_edge", {15'd0, bus0.in_ready}, 16'd0);
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_rst", {15'd0, bus0.in_ready}, 16'd1);

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      do_op(i, i == 0);
    end

    // Backpressure: result held while out_ready=0, new operands ignored
    set_oready(1'b0);
    launch(11, ok);
    seen = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus0.out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("bp_valid_seen", {15'd0, seen}, 16'd1);
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      set_in(1'b1, 16'h1111, 16'h2222);
      @(negedge clk);
      chk("bp_out_valid", {15'd0, bus0.out_valid}, 16'd1);
      chk("bp_c", bus0.c, tbl[11].c);
      chk("bp_ovf", {15'd0, bus0.ovf}, {15'd0, tbl[11].ovf});
      chk("bp_c_s0", bus2.c, tbl[11].c_s0);
      chk("bp_in_ready", {15'd0, bus0.in_ready}, 16'd0);
    end
    @(posedge clk); #1;
    set_in(1'b0, 16'h0000, 16'h0000);
    set_oready(1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_valid_dropped", {15'd0, bus0.out_valid}, 16'd0);
    chk("bp_in_ready_back", {15'd0, bus0.in_ready}, 16'd1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus0.out_valid) seen = 1'b1;
    end
    chk("bp_ignored_in", {15'd0, seen}, 16'd0);

    // Reset in the middle of BUSY aborts the operation
    launch(4, ok);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    q2.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", {15'd0, bus0.out_valid}, 16'd0);
    chk("midrst_c", bus0.c, 16'h0000);
    chk("midrst_in_ready", {15'd0, bus0.in_ready}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus0.out_valid || bus1.out_valid || bus2.out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", {15'd0, seen}, 16'd0);
    chk("midrst_c_hold", bus0.c, 16'h0000);
    do_op(7, 1'b1);

    repeat (3) @(posedge clk);
    chk("queue0_empty", 16'(q0.size()), 16'd0);
    chk("queue1_empty", 16'(q1.size()), 16'd0);
    chk("queue2_empty", 16'(q2.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
